// File: rtl/fmap_collector_pkg.sv
// rtl/fmap_collector_pkg.sv - shared state encoding for the frame collector
package fmap_collector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

endpackage

// File: rtl/fmap_collector_frame_ram.sv
// rtl/fmap_collector_frame_ram.sv - 1W/1R synchronous frame RAM, read-first
module fmap_collector_frame_ram #(
    parameter int   DATA_W = 8,
    parameter int   DEPTH  = 784,
    localparam int  ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Separate process samples the array before this edge's write lands.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fmap_collector.sv
// rtl/fmap_collector.sv - captures one pixel frame, tracks checksum and stream errors
module fmap_collector
    import fmap_collector_pkg::*;
#(
    parameter int  PIX_BW       = 8,
    parameter int  TOTAL_PIXELS = 784,
    parameter int  GAP_TIMEOUT  = 16,
    localparam int ADDR_BW      = $clog2(TOTAL_PIXELS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [PIX_BW-1:0]           i_pixel,
    input  logic                        i_valid,
    input  logic                        i_release,
    input  logic                        i_rd_en,
    input  logic [ADDR_BW-1:0]          i_rd_addr,
    output logic [PIX_BW-1:0]           o_rd_data,
    output logic                        o_rd_valid,
    output logic                        o_frame_done,
    output logic                        o_frame_ready,
    output logic [ADDR_BW:0]            o_pix_count,
    output logic [PIX_BW+ADDR_BW:0]     o_checksum,
    output logic                        o_err_overrun,
    output logic                        o_err_short
);

    localparam int CNT_W  = ADDR_BW + 1;
    localparam int CSUM_W = PIX_BW + ADDR_BW + 1;
    localparam int GAP_W  = $clog2(GAP_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(TOTAL_PIXELS);
    localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(GAP_TIMEOUT);

    state_t              state;
    logic [GAP_W-1:0]    gap_cnt;
    logic [CNT_W-1:0]    next_count;
    logic                wr_en;
    logic [ADDR_BW-1:0]  wr_addr;
    logic                ram_rd_en;
    logic [PIX_BW-1:0]   ram_q;
    logic                rd_valid_q;
    logic                rd_oob_q;

    assign next_count = (state == ST_IDLE) ? CNT_W'(1) : o_pix_count + 1'b1;
    assign wr_en      = i_valid && !reset && (state != ST_FULL);
    assign wr_addr    = (state == ST_IDLE) ? '0 : o_pix_count[ADDR_BW-1:0];
    assign ram_rd_en  = i_rd_en && ({1'b0, i_rd_addr} < FRAME_LEN);

    fmap_collector_frame_ram #(
        .DATA_W (PIX_BW),
        .DEPTH  (TOTAL_PIXELS)
    ) u_frame_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (i_pixel),
        .rd_en   (ram_rd_en),
        .rd_addr (i_rd_addr),
        .rd_data (ram_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            gap_cnt       <= '0;
            o_pix_count   <= '0;
            o_checksum    <= '0;
            o_frame_done  <= 1'b0;
            o_frame_ready <= 1'b0;
            o_err_overrun <= 1'b0;
            o_err_short   <= 1'b0;
        end else begin
            o_frame_done <= 1'b0;
            if (i_release) begin
                o_err_overrun <= 1'b0;
                o_err_short   <= 1'b0;
            end
            case (state)
                ST_IDLE, ST_CAPTURE: begin
                    if (i_valid) begin
                        o_pix_count <= next_count;
                        o_checksum  <= (state == ST_IDLE) ? CSUM_W'(i_pixel)
                                                          : o_checksum + CSUM_W'(i_pixel);
                        gap_cnt     <= '0;
                        if (next_count == FRAME_LEN) begin
                            state         <= ST_FULL;
                            o_frame_done  <= 1'b1;
                            o_frame_ready <= 1'b1;
                        end else begin
                            state <= ST_CAPTURE;
                        end
                    end else if (state == ST_CAPTURE) begin
                        // Partial count and checksum are left visible after an abort.
                        if (gap_cnt >= GAP_LIMIT - 1'b1) begin
                            gap_cnt     <= GAP_LIMIT;
                            o_err_short <= 1'b1;
                            state       <= ST_IDLE;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                end
                ST_FULL: begin
                    if (i_release) begin
                        o_frame_ready <= 1'b0;
                        state         <= ST_IDLE;
                    end else if (i_valid) begin
                        o_err_overrun <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_oob_q   <= 1'b0;
        end else begin
            rd_valid_q <= i_rd_en;
            rd_oob_q   <= !ram_rd_en;
        end
    end

    assign o_rd_valid = rd_valid_q;
    assign o_rd_data  = (rd_valid_q && !rd_oob_q) ? ram_q : '0;

endmodule

// File: tb/tb_fmap_collector.sv
// tb/tb_fmap_collector.sv - scoreboard bench for fmap_collector
module tb_fmap_collector;

    localparam int PIX_BW  = 8;
    localparam int TOTAL   = 784;
    localparam int GAP     = 16;
    localparam int ADDR_BW = 10;

    typedef struct {
        int cnt;
        int sum;
    } done_t;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [PIX_BW-1:0]      i_pixel = '0;
    logic                   i_valid = 1'b0;
    logic                   i_release = 1'b0;
    logic                   i_rd_en = 1'b0;
    logic [ADDR_BW-1:0]     i_rd_addr = '0;
    logic [PIX_BW-1:0]      o_rd_data;
    logic                   o_rd_valid;
    logic                   o_frame_done;
    logic                   o_frame_ready;
    logic [ADDR_BW:0]       o_pix_count;
    logic [PIX_BW+ADDR_BW:0] o_checksum;
    logic                   o_err_overrun;
    logic                   o_err_short;

    int    tests = 0;
    int    fails = 0;
    int    ref_mem [TOTAL];
    int    rd_q [$];
    done_t done_q [$];
    int    last_sum;

    fmap_collector #(
        .PIX_BW       (PIX_BW),
        .TOTAL_PIXELS (TOTAL),
        .GAP_TIMEOUT  (GAP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_pixel       (i_pixel),
        .i_valid       (i_valid),
        .i_release     (i_release),
        .i_rd_en       (i_rd_en),
        .i_rd_addr     (i_rd_addr),
        .o_rd_data     (o_rd_data),
        .o_rd_valid    (o_rd_valid),
        .o_frame_done  (o_frame_done),
        .o_frame_ready (o_frame_ready),
        .o_pix_count   (o_pix_count),
        .o_checksum    (o_checksum),
        .o_err_overrun (o_err_overrun),
        .o_err_short   (o_err_short)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_rd(input int a);
        return (a < TOTAL) ? ref_mem[a] : 0;
    endfunction

    task automatic cycle(input bit v, input int p, input bit rel, input bit rd, input int ra);
        i_valid   = v;
        i_pixel   = PIX_BW'(p);
        i_release = rel;
        i_rd_en   = rd;
        i_rd_addr = ADDR_BW'(ra);
        @(posedge clk);
        #1;
        i_valid   = 1'b0;
        i_release = 1'b0;
        i_rd_en   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
    endtask

    task automatic read_at(input int a);
        rd_q.push_back(exp_rd(a));
        cycle(0, 0, 0, 1, a);
    endtask

    // Pixels land at addresses 0..n-1; concurrent reads see the buffer as it was before this cycle.
    task automatic send_stream(input int n, input int gap_at, input int gap_len, input bit pattern);
        int sum = 0;
        done_t d;
        for (int k = 0; k < n; k++) begin
            int p;
            bit rd;
            int ra;
            if (k == gap_at) idle(gap_len);
            else if (k > 0 && $urandom_range(0, 31) == 0) idle(int'($urandom_range(1, GAP - 1)));
            p  = pattern ? (k % 256) : int'($urandom_range(0, 255));
            rd = ($urandom_range(0, 7) == 0);
            ra = ($urandom_range(0, 1) == 1) ? k : int'($urandom_range(0, 1023));
            if (rd) rd_q.push_back(exp_rd(ra));
            cycle(1, p, 0, rd, ra);
            ref_mem[k] = p;
            sum += p;
        end
        last_sum = sum;
        if (n == TOTAL) begin
            d.cnt = TOTAL;
            d.sum = sum;
            done_q.push_back(d);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_data"},  int'(o_rd_data), 0);
        check({tag, "_rd_valid"}, int'(o_rd_valid), 0);
        check({tag, "_done"},     int'(o_frame_done), 0);
        check({tag, "_ready"},    int'(o_frame_ready), 0);
        check({tag, "_count"},    int'(o_pix_count), 0);
        check({tag, "_checksum"}, int'(o_checksum), 0);
        check({tag, "_overrun"},  int'(o_err_overrun), 0);
        check({tag, "_short"},    int'(o_err_short), 0);
    endtask

    always @(negedge clk) begin
        if (o_rd_valid) begin
            if (rd_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rd_unexpected: got data %0d, expected no read response", o_rd_data);
            end else begin
                check("rd_data", int'(o_rd_data), rd_q.pop_front());
            end
        end
        if (o_frame_done) begin
            if (done_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL done_unexpected: got frame_done with count %0d, expected none", o_pix_count);
            end else begin
                done_t d;
                d = done_q.pop_front();
                check("done_count", int'(o_pix_count), d.cnt);
                check("done_sum", int'(o_checksum), d.sum);
                check("done_ready", int'(o_frame_ready), 1);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < TOTAL; i++) ref_mem[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        // Contiguous k mod 256 frame, then boundary reads
        send_stream(TOTAL, -1, 0, 1);
        idle(1);
        check("t1_ready", int'(o_frame_ready), 1);
        check("t1_count", int'(o_pix_count), TOTAL);
        check("t1_sum", int'(o_checksum), last_sum);
        check("t1_overrun", int'(o_err_overrun), 0);
        check("t1_short", int'(o_err_short), 0);
        read_at(0); read_at(255); read_at(256); read_at(783); read_at(784); read_at(1023);
        cycle(0, 0, 1, 0, 0);
        check("t1_release_ready", int'(o_frame_ready), 0);

        // Frame with a 10-cycle gap at pixel 300
        send_stream(TOTAL, 300, 10, 0);
        idle(1);
        check("t2_short", int'(o_err_short), 0);
        check("t2_ready", int'(o_frame_ready), 1);
        check("t2_sum", int'(o_checksum), last_sum);
        cycle(0, 0, 1, 0, 0);

        // Short frame aborted by gap timeout, then a full frame with the error sticky
        send_stream(500, -1, 0, 0);
        idle(GAP + 4);
        check("t3_short", int'(o_err_short), 1);
        check("t3_count", int'(o_pix_count), 500);
        check("t3_sum", int'(o_checksum), last_sum);
        check("t3_ready", int'(o_frame_ready), 0);
        send_stream(TOTAL, -1, 0, 0);
        idle(1);
        check("t3_short_sticky", int'(o_err_short), 1);
        check("t3_full_ready", int'(o_frame_ready), 1);

        // Overrun: extra pixels dropped, buffer untouched
        for (int i = 0; i < 3; i++) cycle(1, int'($urandom_range(0, 255)), 0, 0, 0);
        check("t4_overrun", int'(o_err_overrun), 1);
        check("t4_count", int'(o_pix_count), TOTAL);
        read_at(0); read_at(1); read_at(2);
        for (int i = 0; i < 3; i++) read_at(int'($urandom_range(0, TOTAL - 1)));
        cycle(0, 0, 1, 0, 0);
        check("t4_rel_overrun", int'(o_err_overrun), 0);
        check("t4_rel_short", int'(o_err_short), 0);
        check("t4_rel_ready", int'(o_frame_ready), 0);

        // Release and valid together in FULL: release wins
        send_stream(TOTAL, -1, 0, 0);
        idle(2);
        cycle(1, 8'hAA, 1, 0, 0);
        check("t5_overrun", int'(o_err_overrun), 0);
        check("t5_ready", int'(o_frame_ready), 0);
        begin
            int p0;
            p0 = int'($urandom_range(0, 255));
            cycle(1, p0, 0, 0, 0);
            ref_mem[0] = p0;
            check("t5_first_count", int'(o_pix_count), 1);
            check("t5_first_sum", int'(o_checksum), p0);
            read_at(0);
        end
        idle(GAP + 4);
        check("t5_abort_short", int'(o_err_short), 1);

        // Reset in the middle of a frame
        send_stream(400, -1, 0, 0);
        idle(1);
        reset = 1'b1;
        cycle(0, 0, 0, 0, 0);
        check_all_zero("t6_reset");
        reset = 1'b0;
        send_stream(TOTAL, -1, 0, 0);
        idle(1);
        check("t6_count", int'(o_pix_count), TOTAL);
        check("t6_ready", int'(o_frame_ready), 1);

        // Randomized frames with a random in-frame gap
        for (int f = 0; f < 3; f++) begin
            cycle(0, 0, 1, 0, 0);
            send_stream(TOTAL, int'($urandom_range(1, TOTAL - 1)), int'($urandom_range(1, GAP - 1)), 0);
            idle(1);
            check("tr_sum", int'(o_checksum), last_sum);
            check("tr_short", int'(o_err_short), 0);
            for (int i = 0; i < 4; i++) read_at(int'($urandom_range(0, 1023)));
        end

        idle(3);
        check("rd_q_drained", rd_q.size(), 0);
        check("done_q_drained", done_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
